wordcap: RTL and testbench

- Serial receive counterpart of the word generator's transmit path.
- Deserialises 8N1 frames (idle-high, LSB first) arriving on a single line.
- Assembles received bytes into a word buffer, terminated by a configurable terminator byte.
- Exposes each completed word through a read port, so a loopback bench or downstream logic can check the words the generator sends.

---
 rtl/wordcap.sv | 133 +++++++++++++
 tb/tb_wordcap.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/wordcap.sv
// wordcap: 8N1 serial receiver that assembles terminator-delimited words into a readable buffer.
module wordcap #(
    parameter int          CLKS_PER_BIT = 5208,
    parameter logic [7:0]  TERM         = 8'h0D,
    parameter int          MAX_LEN      = 11
) (
    input  logic       sysclk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic [3:0] rd_addr,
    output logic [7:0] rd_data,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       frame_err,
    output logic       word_done,
    output logic [3:0] word_len,
    output logic       overflow,
    output logic       busy
);
    localparam int          CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [3:0]  ML   = 4'(MAX_LEN);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    shift, shift_n, bd_n;
    logic          bv_n, fe_n;
    logic          s1, rs, rp;
    logic [3:0]    count;
    logic [7:0]    mem [16];

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b1;
            rs <= 1'b1;
            rp <= 1'b1;
        end else begin
            s1 <= rx;
            rs <= s1;
            rp <= rs;
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            shift      <= '0;
            byte_data  <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            idx        <= idx_n;
            shift      <= shift_n;
            byte_data  <= bd_n;
            byte_valid <= bv_n;
            frame_err  <= fe_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        idx_n   = idx;
        shift_n = shift;
        bd_n    = byte_data;
        bv_n    = 1'b0;
        fe_n    = 1'b0;
        case (state)
            IDLE: begin
                cnt_n   = '0;
                state_n = (rp && !rs) ? START : IDLE;
            end
            START: if (cnt == HALF) begin
                cnt_n   = '0;
                idx_n   = '0;
                state_n = rs ? IDLE : DATA;
            end
            DATA: if (cnt == FULL) begin
                cnt_n       = '0;
                shift_n[idx] = rs;
                idx_n       = idx + 1'b1;
                state_n     = (idx == 3'd7) ? STOP : DATA;
            end
            default: if (cnt == FULL) begin
                cnt_n   = '0;
                state_n = IDLE;
                bv_n    = rs;
                fe_n    = !rs;
                bd_n    = rs ? shift : byte_data;
            end
        endcase
    end

    // Word assembly trails byte_valid by one cycle, so its pulses never overlap the byte's own.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            word_len  <= '0;
            word_done <= 1'b0;
            overflow  <= 1'b0;
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else begin
            word_done <= 1'b0;
            overflow  <= 1'b0;
            if (frame_err)
                count <= '0;
            else if (byte_valid) begin
                if (byte_data == TERM) begin
                    if (count != 4'd0) begin
                        word_len  <= count;
                        word_done <= 1'b1;
                        count     <= '0;
                    end
                end else if (count < ML) begin
                    mem[count] <= byte_data;
                    count      <= count + 4'd1;
                end else
                    overflow <= 1'b1;
            end
        end
    end

    assign rd_data = (rd_addr < ML) ? mem[rd_addr] : 8'h00;
    assign busy    = (state != IDLE);
endmodule

// File: tb/tb_wordcap.sv
// tb_wordcap: directed-vector bench for the wordcap serial word receiver.
module tb_wordcap;
    localparam int CPB = 16;

    logic       sysclk = 1'b0;
    logic       rst_n  = 1'b0;
    logic       rx     = 1'b1;
    logic [3:0] rd_addr = '0;
    logic [7:0] rd_data, byte_data;
    logic       byte_valid, frame_err, word_done, overflow, busy;
    logic [3:0] word_len;

    int n_tests = 0, n_fail = 0;
    int nbv = 0, nfe = 0, nwd = 0, nov = 0, nbusy = 0;
    logic [7:0] blog [256];
    logic [7:0] ov_byte = '0;
    int b_bv, b_fe, b_wd, b_ov, b_busy;

    wordcap #(.CLKS_PER_BIT(CPB), .TERM(8'h0D), .MAX_LEN(11)) dut (
        .sysclk(sysclk), .rst_n(rst_n), .rx(rx), .rd_addr(rd_addr), .rd_data(rd_data),
        .byte_data(byte_data), .byte_valid(byte_valid), .frame_err(frame_err),
        .word_done(word_done), .word_len(word_len), .overflow(overflow), .busy(busy)
    );

    always #5 sysclk = ~sysclk;

    always @(negedge sysclk) begin
        if (byte_valid) begin
            blog[nbv[7:0]] = byte_data;
            nbv++;
        end
        if (frame_err) nfe++;
        if (word_done) nwd++;
        if (overflow) begin
            nov++;
            ov_byte = byte_data;
        end
        if (busy) nbusy++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge sysclk);
        rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            idle(CPB);
        end
        rx = stop;
        idle(CPB);
        rx = 1'b1;
        idle(6);
    endtask

    task automatic snap();
        b_bv = nbv; b_fe = nfe; b_wd = nwd; b_ov = nov; b_busy = nbusy;
    endtask

    task automatic read_at(input logic [3:0] a, input logic [7:0] exp, input string tag);
        rd_addr = a;
        #1;
        check(tag, rd_data, exp);
    endtask

    initial begin
        logic [7:0] hello [5];
        hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
        #1;
        check("rst_byte_data", byte_data, 0);
        check("rst_pulses", {byte_valid, frame_err, word_done, overflow, busy}, 0);
        check("rst_word_len", word_len, 0);
        idle(3);
        rst_n = 1'b1;
        idle(5);

        snap();
        send_byte(8'h0D, 1'b1);
        send_byte(8'h0D, 1'b1);
        check("dbl_term_bv", nbv - b_bv, 2);
        check("dbl_term_wd", nwd - b_wd, 0);
        check("dbl_term_len", word_len, 0);

        snap();
        for (int i = 0; i < 5; i++) send_byte(hello[i], 1'b1);
        send_byte(8'h0D, 1'b1);
        check("hello_bv", nbv - b_bv, 6);
        for (int i = 0; i < 5; i++) check("hello_byte", blog[b_bv + i], hello[i]);
        check("hello_wd", nwd - b_wd, 1);
        check("hello_len", word_len, 5);
        for (int i = 0; i < 5; i++) read_at(4'(i), hello[i], "hello_rd");
        read_at(4'd12, 8'h00, "hello_rd12");

        snap();
        for (int i = 0; i < 12; i++) send_byte(8'h41 + 8'(i), 1'b1);
        send_byte(8'h0D, 1'b1);
        check("ovf_count", nov - b_ov, 1);
        check("ovf_byte", ov_byte, 8'h4C);
        check("ovf_wd", nwd - b_wd, 1);
        check("ovf_len", word_len, 11);
        read_at(4'd10, 8'h4B, "ovf_rd10");
        read_at(4'd11, 8'h00, "ovf_rd11");

        snap();
        send_byte(8'h41, 1'b0);
        send_byte(8'h42, 1'b1);
        send_byte(8'h0D, 1'b1);
        check("ferr_fe", nfe - b_fe, 1);
        check("ferr_bv", nbv - b_bv, 2);
        check("ferr_first", blog[b_bv], 8'h42);
        check("ferr_wd", nwd - b_wd, 1);
        check("ferr_len", word_len, 1);
        read_at(4'd0, 8'h42, "ferr_rd0");

        snap();
        @(negedge sysclk);
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(40);
        check("glitch_busy_seen", (nbusy - b_busy) > 0, 1);
        check("glitch_busy_end", busy, 0);
        check("glitch_bv", nbv - b_bv, 0);
        check("glitch_fe", nfe - b_fe, 0);

        send_byte(8'h51, 1'b1);
        snap();
        @(negedge sysclk);
        rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 3; i++) begin
            rx = 1'(8'h5A >> i);
            idle(CPB);
        end
        check("mid_busy", busy, 1);
        rst_n = 1'b0;
        rx    = 1'b1;
        rd_addr = 4'd0;
        #1;
        check("rst2_outs", {byte_data, byte_valid, frame_err, word_done, overflow, busy}, 0);
        check("rst2_len", word_len, 0);
        check("rst2_rd0", rd_data, 8'h00);
        idle(3);
        rst_n = 1'b1;
        idle(40);
        check("rst2_quiet", (nbv - b_bv) + (nfe - b_fe) + (nwd - b_wd) + (nov - b_ov), 0);
        snap();
        send_byte(8'h5A, 1'b1);
        send_byte(8'h0D, 1'b1);
        check("rst2_bv", nbv - b_bv, 2);
        check("rst2_wd", nwd - b_wd, 1);
        check("rst2_wlen", word_len, 1);
        read_at(4'd0, 8'h5A, "rst2_rd0z");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
